// File: rtl/fft_axil_ctrl_regs.sv
// rtl/fft_axil_ctrl_regs.sv - AXI4-Lite control/status register file for the FFT core
module fft_axil_ctrl_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 9,
  parameter int FRAME_CNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            cfg_ifft,
  output logic [3:0]                      cfg_point,
  output logic [4:0]                      cfg_final_shift,
  output logic [17:0]                     cfg_scaling,
  output logic                            fft_start,
  output logic                            fft_stop,
  output logic                            fft_run,
  input  logic                            fft_done,
  input  logic                            fft_busy
);

  localparam int WI = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [WI-1:0] W_CONFIG  = WI'(0);
  localparam logic [WI-1:0] W_COMMAND = WI'(1);
  localparam logic [WI-1:0] W_STATUS  = WI'(2);

  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [WI-1:0]          wr_addr;
  logic [WI-1:0]          rd_addr;
  logic [1:0]             cmd_reg;
  logic                   cmd_go;
  logic                   done_sticky;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [31:0]            rd_mux;
  logic                   wr_en;

  // Low address bits and strobes carry no information for full-word registers
  logic unused_bits;
  assign unused_bits = &{1'b0, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = (wr_state == WR_ACCEPT);
  assign S_AXI_WREADY  = (wr_state == WR_ACCEPT);
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = (rd_state == RD_ACCEPT);
  assign S_AXI_RVALID  = (rd_state == RD_DATA);
  assign S_AXI_RRESP   = 2'b00;
  assign wr_en         = (wr_state == WR_ACCEPT);

  // Write channel state register
  always_ff @(posedge clk) begin
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  // Write channel: accept address+data together, one ready cycle, then hold response
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = WR_ACCEPT;
      WR_ACCEPT: wr_next = WR_RESP;
      WR_RESP:   if (S_AXI_BREADY) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  // Write address is taken on the first edge; data arrives on the following edge
  always_ff @(posedge clk) begin
    if (!rst_n)
      wr_addr <= '0;
    else if (wr_state == WR_IDLE && S_AXI_AWVALID && S_AXI_WVALID)
      wr_addr <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  end

  // Register file, command execution one cycle after capture, frame accounting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ifft        <= 1'b0;
      cfg_point       <= '0;
      cfg_final_shift <= '0;
      cfg_scaling     <= '0;
      cmd_reg         <= '0;
      cmd_go          <= 1'b0;
      fft_start       <= 1'b0;
      fft_stop        <= 1'b0;
      fft_run         <= 1'b0;
      done_sticky     <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      cmd_go    <= 1'b0;
      fft_start <= 1'b0;
      fft_stop  <= 1'b0;

      if (wr_en) begin
        if (wr_addr == W_CONFIG && !fft_run) begin
          cfg_ifft        <= S_AXI_WDATA[31];
          cfg_point       <= S_AXI_WDATA[30:27];
          cfg_final_shift <= S_AXI_WDATA[26:22];
          cfg_scaling     <= S_AXI_WDATA[21:4];
        end
        if (wr_addr == W_COMMAND) begin
          cmd_reg <= S_AXI_WDATA[1:0];
          cmd_go  <= 1'b1;
        end
      end

      // Frame completion; an abort in the same cycle overrides below
      if (fft_done && fft_run) begin
        done_sticky <= 1'b1;
        if (frame_cnt != {FRAME_CNT_W{1'b1}})
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end

      if (cmd_go) begin
        case (cmd_reg)
          2'd1: if (!fft_run) begin
            fft_start <= 1'b1;
            fft_run   <= 1'b1;
          end
          2'd2: if (fft_run) begin
            fft_stop <= 1'b1;
            fft_run  <= 1'b0;
          end
          2'd3: begin
            fft_stop    <= fft_run;
            fft_run     <= 1'b0;
            done_sticky <= 1'b0;
            frame_cnt   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Read channel state register
  always_ff @(posedge clk) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  // Read channel: one ready cycle, then data held until taken
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:   if (S_AXI_ARVALID) rd_next = RD_ACCEPT;
      RD_ACCEPT: rd_next = RD_DATA;
      RD_DATA:   if (S_AXI_RREADY) rd_next = RD_IDLE;
      default:   rd_next = RD_IDLE;
    endcase
  end

  // Read data selection from live register values (pre-update on a coincident done)
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      W_CONFIG:  rd_mux = {cfg_ifft, cfg_point, cfg_final_shift, cfg_scaling, 4'b0000};
      W_COMMAND: rd_mux[1:0] = cmd_reg;
      W_STATUS: begin
        rd_mux[31]               = fft_run;
        rd_mux[30]               = fft_busy;
        rd_mux[29]               = done_sticky;
        rd_mux[28]               = fft_run;
        rd_mux[FRAME_CNT_W-1:0]  = frame_cnt;
      end
      default:   rd_mux = '0;
    endcase
  end

  // Read address latch and registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr     <= '0;
      S_AXI_RDATA <= '0;
    end else begin
      if (rd_state == RD_IDLE && S_AXI_ARVALID)
        rd_addr <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (rd_state == RD_ACCEPT)
        S_AXI_RDATA <= C_S_AXI_DATA_WIDTH'(rd_mux);
    end
  end

endmodule

// File: tb/tb_fft_axil_ctrl_regs.sv
// tb/tb_fft_axil_ctrl_regs.sv - scoreboard testbench for fft_axil_ctrl_regs
module tb_fft_axil_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        cfg_ifft, fft_start, fft_stop, fft_run, fft_done, fft_busy;
  logic [3:0]  cfg_point;
  logic [4:0]  cfg_final_shift;
  logic [17:0] cfg_scaling;

  always #5 clk = ~clk;

  fft_axil_ctrl_regs dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_ifft(cfg_ifft), .cfg_point(cfg_point), .cfg_final_shift(cfg_final_shift),
    .cfg_scaling(cfg_scaling), .fft_start(fft_start), .fft_stop(fft_stop), .fft_run(fft_run),
    .fft_done(fft_done), .fft_busy(fft_busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Scoreboard queues: expected write responses, read data, and control pulses (1=start, 2=stop)
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  int          pq[$];

  // Reference model of the register map
  logic [31:0] cfg_m;
  logic [1:0]  cmd_m;
  logic        run_m, sticky_m;
  int          cnt_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int word);
    logic [31:0] v;
    v = 32'h0;
    case (word)
      0: v = cfg_m;
      1: v[1:0] = cmd_m;
      2: begin
        v[31] = run_m; v[30] = fft_busy; v[29] = sticky_m; v[28] = run_m;
        v[15:0] = cnt_m[15:0];
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // Monitor: compares every completed handshake and every control pulse against the queues
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'(bvalid), 32'h0);
        else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'(rvalid), 32'h0);
        else begin
          chk("rdata", rdata, rq.pop_front());
          chk("rresp", 32'(rresp), 32'h0);
        end
      end
      if (fft_start) begin
        if (pq.size() == 0) chk("start_unexpected", 32'(fft_start), 32'h0);
        else chk("pulse_start", 32'd1, 32'(pq.pop_front()));
      end
      if (fft_stop) begin
        if (pq.size() == 0) chk("stop_unexpected", 32'(fft_stop), 32'h0);
        else chk("pulse_stop", 32'd2, 32'(pq.pop_front()));
      end
    end
  end

  task automatic wr_raw(input logic [8:0] a, input logic [31:0] d, input bit late, input int bd);
    int n;
    awaddr = a; wdata = late ? ~d : d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    chk("awready_seen", 32'(awready), 32'h1);
    chk("wready_seen", 32'(wready), 32'h1);
    if (late) begin wdata = d; awaddr = a ^ 9'h004; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("awready_drop", 32'(awready), 32'h0);
    chk("bvalid_set", 32'(bvalid), 32'h1);
    repeat (bd) begin @(posedge clk); #1; end
    bq.push_back(2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'h0);
  endtask

  // Model update precedes the bus transfer so pulse expectations are queued in time
  task automatic wr_m(input int word, input logic [31:0] d, input bit late, input int bd);
    if (word == 0 && !run_m) cfg_m = d & 32'hFFFF_FFF0;
    if (word == 1) begin
      cmd_m = d[1:0];
      case (d[1:0])
        2'd1: if (!run_m) begin pq.push_back(1); run_m = 1'b1; end
        2'd2: if (run_m) begin pq.push_back(2); run_m = 1'b0; end
        2'd3: begin
          if (run_m) pq.push_back(2);
          run_m = 1'b0; sticky_m = 1'b0; cnt_m = 0;
        end
        default: ;
      endcase
    end
    wr_raw(9'(word * 4), d, late, bd);
  endtask

  task automatic rd_m(input int word, input int rdly);
    int lat;
    rq.push_back(exp_rd(word));
    araddr = 9'(word * 4); arvalid = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rvalid && lat < 20);
    arvalid = 1'b0;
    chk("read_latency", 32'(lat), 32'd2);
    repeat (rdly) begin @(posedge clk); #1; end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic done_pulse();
    fft_done = 1'b1;
    if (run_m) begin
      sticky_m = 1'b1;
      if (cnt_m < 65535) cnt_m++;
    end
    @(posedge clk); #1;
    fft_done = 1'b0;
  endtask

  task automatic chk_ports(input string nm);
    chk({nm, "_cfg"}, {cfg_ifft, cfg_point, cfg_final_shift, cfg_scaling, 4'b0}, cfg_m);
    chk({nm, "_run"}, 32'(fft_run), 32'(run_m));
  endtask

  task automatic model_reset();
    cfg_m = 32'h0; cmd_m = 2'b0; run_m = 1'b0; sticky_m = 1'b0; cnt_m = 0;
  endtask

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0; wdata = '0; wstrb = 4'hF; fft_done = 0; fft_busy = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_axi", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulses", {30'b0, fft_start, fft_stop}, 32'h0);
    chk_ports("rst");

    // Basic config write and readback
    wr_m(0, {1'b0, 4'd9, 5'd0, 18'b010101010101010101, 4'b0}, 1'b0, 0);
    chk("cfg_point", 32'(cfg_point), 32'd9);
    chk("cfg_scaling", 32'(cfg_scaling), 32'h15555);
    rd_m(0, 0);

    // Late write data during the ready cycle, address from the first edge
    wr_m(0, 32'hA5C3_96E0, 1'b1, 2);
    chk_ports("late");
    rd_m(0, 1);
    rd_m(1, 0);

    // Start, locked config, frames, stop
    wr_m(1, 32'd1, 1'b0, 0);
    chk_ports("start");
    wr_m(0, 32'h1234_5670, 1'b0, 1);
    chk_ports("locked");
    fft_busy = 1'b1;
    repeat (3) begin done_pulse(); repeat (2) @(posedge clk); #1; end
    rd_m(2, 0);
    wr_m(1, 32'd1, 1'b0, 0);
    wr_m(1, 32'd2, 1'b0, 0);
    chk_ports("stop");
    done_pulse();
    rd_m(2, 2);

    // Abort clears accounting; unmapped word
    wr_m(1, 32'd1, 1'b0, 0);
    done_pulse(); done_pulse();
    wr_m(1, 32'd3, 1'b0, 1);
    rd_m(2, 0);
    wr_m(5, 32'hFFFF_FFFF, 1'b0, 0);
    rd_m(5, 0);
    fft_busy = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: wr_m(0, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        1: wr_m(1, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        2: rd_m($urandom_range(0, 6), $urandom_range(0, 2));
        3: done_pulse();
        default: begin fft_busy = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
      endcase
    end
    chk_ports("rand");

    // Reset while a write response is pending
    if (!run_m) wr_m(1, 32'd1, 1'b0, 0);
    awaddr = 9'h004; wdata = 32'd2; awvalid = 1'b1; wvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    chk("pend_bvalid", 32'(bvalid), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rst2_axi", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    chk("rst2_misc", {rdata[29:0], fft_start, fft_stop}, 32'h0);
    chk_ports("rst2");
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst2_no_stop", 32'(fft_run), 32'h0);
    rd_m(2, 0);
    rd_m(1, 0);

    repeat (4) @(posedge clk); #1;
    chk("bq_empty", 32'(bq.size()), 32'h0);
    chk("rq_empty", 32'(rq.size()), 32'h0);
    chk("pq_empty", 32'(pq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
